// File: rtl/fft_peak_detect.sv
// Spectral peak detector: finds the strongest bin of each framed FFT
// magnitude-squared stream and reports index/energy once per good frame.
// Ports: sys_clk, sys_rst (sync, active-high); in_amp/in_valid/in_sop/in_eop
// input beats; peak_idx/peak_amp/peak_valid result; frame_err pulse on bad
// framing; frame_cnt good-frame count; busy while a frame is in progress.
// Option: define FFT_PEAK_SKIP_DC_EN to exclude bins 0 and 1 from the search.
module fft_peak_detect #(
  parameter int N     = 1024,
  parameter int IDX_W = 10,
  parameter int AMP_W = 25
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [AMP_W-1:0] in_amp,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic [IDX_W-1:0] peak_idx,
  output logic [AMP_W-1:0] peak_amp,
  output logic             peak_valid,
  output logic             frame_err,
  output logic [15:0]      frame_cnt,
  output logic             busy
);

  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] bin;
  logic [AMP_W-1:0] run_max;
  logic [IDX_W-1:0] run_idx;
  logic [AMP_W-1:0] init_max;
  logic [IDX_W-1:0] init_idx;

  logic start;
  logic both;
  logic acc_beat;
  logic good;
  logic err;
  logic search;
  logic upd;

  // Beat classification. bin is the index of the current beat in ACC.
  always_comb begin
    bin      = cnt + 1'b1;
    start    = in_valid && in_sop && !in_eop;
    both     = in_valid && in_sop && in_eop;
    acc_beat = in_valid && (state == ACC) && !in_sop;
    good     = acc_beat && in_eop && (bin == LAST);
    err      = both
            || (in_valid && in_sop && (state == ACC))
            || (acc_beat && in_eop && (bin != LAST))
            || (acc_beat && !in_eop && (bin == LAST));
`ifdef FFT_PEAK_SKIP_DC_EN
    // Bin 0 never reaches this path; bin 1 is DC leakage.
    search   = !bin[IDX_W-1] && (bin != IDX_W'(1));
    init_max = '0;
    init_idx = IDX_W'(2);
`else
    // Upper half mirrors the lower half for a real input.
    search   = !bin[IDX_W-1];
    init_max = in_amp;
    init_idx = '0;
`endif
    upd      = acc_beat && !in_eop && search && (in_amp > run_max);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = ACC;
      end
      ACC: begin
        if (start)
          state_next = ACC;
        else if (both)
          state_next = IDLE;
        else if (acc_beat && (in_eop || bin == LAST))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACC);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt        <= '0;
      run_max    <= '0;
      run_idx    <= '0;
      peak_idx   <= '0;
      peak_amp   <= '0;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      peak_valid <= good;
      frame_err  <= err;
      if (start) begin
        cnt     <= '0;
        run_max <= init_max;
        run_idx <= init_idx;
      end else if (acc_beat) begin
        cnt <= bin;
        if (upd) begin
          run_max <= in_amp;
          run_idx <= bin;
        end
      end
      if (good) begin
        peak_idx  <= run_idx;
        peak_amp  <= run_max;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect (N=16) against a frame-level
// reference model built on a queue of received bin energies.
module tb_fft_peak_detect;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [AW-1:0] in_amp = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic [IW-1:0] peak_idx;
  logic [AW-1:0] peak_amp;
  logic          peak_valid;
  logic          frame_err;
  logic [15:0]   frame_cnt;
  logic          busy;

  fft_peak_detect #(.N(N), .IDX_W(IW), .AMP_W(AW)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .in_amp(in_amp), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop),
    .peak_idx(peak_idx), .peak_amp(peak_amp),
    .peak_valid(peak_valid), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pv_seen = 0;
  int fe_seen = 0;

  always @(negedge clk) begin
    if (peak_valid === 1'b1) pv_seen++;
    if (frame_err === 1'b1) fe_seen++;
  end

  // Reference model: frame buffer plus expected outputs.
  bit          m_in;
  int unsigned m_buf[$];
  int unsigned m_idx, m_amp, m_cnt;
  int          m_pv, m_fe;
  bit          m_pv_now, m_fe_now;

  function automatic void model_reset();
    m_in = 0;
    m_buf.delete();
    m_idx = 0;
    m_amp = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_close();
    int unsigned best, bi;
`ifdef FFT_PEAK_SKIP_DC_EN
    best = 0;
    bi = 2;
    for (int i = 2; i < N / 2; i++)
      if (m_buf[i] > best) begin best = m_buf[i]; bi = i; end
`else
    best = m_buf[0];
    bi = 0;
    for (int i = 1; i < N / 2; i++)
      if (m_buf[i] > best) begin best = m_buf[i]; bi = i; end
`endif
    m_idx = bi;
    m_amp = best;
    m_cnt = (m_cnt + 1) % 65536;
    m_pv++;
    m_pv_now = 1;
  endfunction

  function automatic void model_beat(int unsigned a, bit sop, bit eop);
    m_pv_now = 0;
    m_fe_now = 0;
    if (sop) begin
      if (m_in || eop) begin m_fe++; m_fe_now = 1; end
      m_in = !eop;
      m_buf.delete();
      m_buf.push_back(a);
    end else if (m_in) begin
      m_buf.push_back(a);
      if (eop) begin
        if (m_buf.size() == N) model_close();
        else begin m_fe++; m_fe_now = 1; end
        m_in = 0;
      end else if (m_buf.size() == N) begin
        m_fe++;
        m_fe_now = 1;
        m_in = 0;
      end
    end
  endfunction

  task automatic beat(int unsigned a, bit sop, bit eop);
    in_valid = 1'b1;
    in_amp = a[AW-1:0];
    in_sop = sop;
    in_eop = eop;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_beat(a, sop, eop);
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_amp = AW'($urandom);
    in_sop = 1'($urandom);
    in_eop = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(int len, bit with_eop, int maxgap,
                            int unsigned amax);
    for (int k = 0; k < len; k++) begin
      beat($urandom_range(0, amax), k == 0, with_eop && k == len - 1);
      if (k != len - 1)
        repeat ($urandom_range(0, maxgap)) gap();
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    gap();
    gap();
    sys_rst = 1'b0;
    model_reset();
    checks++; if (peak_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d exp 0", peak_idx); end
    checks++; if (peak_amp !== '0) begin errors++; $display("FAIL reset_amp got %0d exp 0", peak_amp); end
    checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b exp 0", peak_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", frame_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_good();
    for (int k = 0; k < N; k++) begin
      beat(k == 3 ? 900 : 5, k == 0, k == N - 1);
      if (k == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_rise got %b exp 1", busy); end
      end
    end
    checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL good_pv got %b exp 1", peak_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_fe got %b exp 0", frame_err); end
    checks++; if (peak_idx !== IW'(3)) begin errors++; $display("FAIL good_idx got %0d exp 3", peak_idx); end
    checks++; if (peak_amp !== AW'(900)) begin errors++; $display("FAIL good_amp got %0d exp 900", peak_amp); end
    checks++; if (frame_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL good_cnt got %0d exp %0d", frame_cnt, m_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy got %b exp 0", busy); end
    gap();
    checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL good_pv_width got %b exp 0", peak_valid); end
    checks++; if (peak_idx !== IW'(3)) begin errors++; $display("FAIL good_hold got %0d exp 3", peak_idx); end
  endtask

  task automatic test_tie_mirror();
    int unsigned a;
    for (int k = 0; k < N; k++) begin
      a = (k == 2 || k == 6) ? 400 : (k == 12 ? 9999 : 1);
      beat(a, k == 0, k == N - 1);
    end
    checks++; if (peak_idx !== IW'(2)) begin errors++; $display("FAIL tie_idx got %0d exp 2", peak_idx); end
    checks++; if (peak_amp !== AW'(400)) begin errors++; $display("FAIL tie_amp got %0d exp 400", peak_amp); end
    gap();
  endtask

  task automatic test_short();
    int c0;
    c0 = m_cnt;
    for (int k = 0; k < 10; k++) beat($urandom_range(0, 1000), k == 0, k == 9);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_fe got %b exp 1", frame_err); end
    checks++; if (peak_valid !== 1'b0) begin errors++; $display("FAIL short_pv got %b exp 0", peak_valid); end
    checks++; if (frame_cnt !== 16'(c0)) begin errors++; $display("FAIL short_cnt got %0d exp %0d", frame_cnt, c0); end
    gap();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL short_fe_width got %b exp 0", frame_err); end
    send_frame(N, 1, 0, 2 ** AW - 1);
    checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL short_next_pv got %b exp 1", peak_valid); end
    checks++; if (peak_idx !== IW'(m_idx)) begin errors++; $display("FAIL short_next_idx got %0d exp %0d", peak_idx, m_idx); end
    checks++; if (peak_amp !== AW'(m_amp)) begin errors++; $display("FAIL short_next_amp got %0d exp %0d", peak_amp, m_amp); end
    gap();
  endtask

  task automatic test_restart();
    int fe0;
    fe0 = m_fe;
    for (int k = 0; k < 7; k++) beat($urandom_range(100, 5000), k == 0, 0);
    for (int k = 0; k < N; k++) begin
      beat(k == 5 ? 77 : $urandom_range(0, 76), k == 0, k == N - 1);
      if (k == 0) begin
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL restart_fe got %b exp 1", frame_err); end
      end
    end
    checks++; if (peak_idx !== IW'(5)) begin errors++; $display("FAIL restart_idx got %0d exp 5", peak_idx); end
    checks++; if (peak_amp !== AW'(77)) begin errors++; $display("FAIL restart_amp got %0d exp 77", peak_amp); end
    gap();
    checks++; if (fe_seen - fe0 !== 1 || m_fe - fe0 !== 1) begin errors++; $display("FAIL restart_fe_count got %0d exp 1", fe_seen - fe0); end
  endtask

  task automatic test_gappy_reset();
    int pv0, fe0;
    for (int k = 0; k < N; k++) begin
      beat(k == 3 ? 900 : 5, k == 0, k == N - 1);
      if (k != N - 1) repeat ($urandom_range(1, 3)) gap();
    end
    checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL gappy_pv got %b exp 1", peak_valid); end
    checks++; if (peak_idx !== IW'(3)) begin errors++; $display("FAIL gappy_idx got %0d exp 3", peak_idx); end
    checks++; if (peak_amp !== AW'(900)) begin errors++; $display("FAIL gappy_amp got %0d exp 900", peak_amp); end
    gap();
    pv0 = pv_seen;
    fe0 = fe_seen;
    for (int k = 0; k < 9; k++) begin
      beat($urandom_range(0, 9000), k == 0, 0);
      if (k != 8) repeat ($urandom_range(0, 2)) gap();
    end
    sys_rst = 1'b1;
    gap();
    sys_rst = 1'b0;
    model_reset();
    gap();
    checks++; if (peak_idx !== '0 || peak_amp !== '0) begin errors++; $display("FAIL midrst_peak got %0d/%0d exp 0/0", peak_idx, peak_amp); end
    checks++; if (frame_cnt !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_cnt_busy got %0d/%b exp 0/0", frame_cnt, busy); end
    checks++; if (pv_seen != pv0 || fe_seen != fe0) begin errors++; $display("FAIL midrst_pulses got %0d/%0d exp %0d/%0d", pv_seen, fe_seen, pv0, fe0); end
  endtask

  task automatic test_dc();
    int unsigned exp_idx;
`ifdef FFT_PEAK_SKIP_DC_EN
    exp_idx = 4;
`else
    exp_idx = 0;
`endif
    for (int k = 0; k < N; k++)
      beat(k == 0 ? 100000 : (k == 4 ? 50 : 0), k == 0, k == N - 1);
    checks++; if (peak_idx !== IW'(exp_idx)) begin errors++; $display("FAIL dc_idx got %0d exp %0d", peak_idx, exp_idx); end
    checks++; if (peak_amp !== AW'(m_amp)) begin errors++; $display("FAIL dc_amp got %0d exp %0d", peak_amp, m_amp); end
    gap();
  endtask

  task automatic test_back_to_back();
    int pv0;
    pv0 = pv_seen;
    send_frame(N, 1, 0, 1000);
    send_frame(N, 1, 0, 1000);
    checks++; if (peak_valid !== 1'b1) begin errors++; $display("FAIL b2b_pv got %b exp 1", peak_valid); end
    checks++; if (peak_idx !== IW'(m_idx) || peak_amp !== AW'(m_amp)) begin errors++; $display("FAIL b2b_peak got %0d/%0d exp %0d/%0d", peak_idx, peak_amp, m_idx, m_amp); end
    gap();
    checks++; if (pv_seen - pv0 != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", pv_seen - pv0); end
  endtask

  task automatic test_random();
    int kind;
    int unsigned amax;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 5);
      amax = ($urandom_range(0, 1) == 1) ? 15 : 2 ** AW - 1;
      unique case (kind)
        0, 1: send_frame(N, 1, 2, amax);
        2: send_frame($urandom_range(2, N - 1), 1, 2, amax);
        3: send_frame(N, 0, 1, amax);
        4: begin
          send_frame($urandom_range(1, N - 1), 0, 1, amax);
          send_frame(N, 1, 1, amax);
        end
        default: begin
          beat($urandom_range(0, amax), 0, $urandom_range(0, 1));
          beat($urandom_range(0, amax), 1, 1);
        end
      endcase
      gap();
      checks++; if (pv_seen != m_pv) begin errors++; $display("FAIL rnd_pv_count f%0d got %0d exp %0d", f, pv_seen, m_pv); end
      checks++; if (fe_seen != m_fe) begin errors++; $display("FAIL rnd_fe_count f%0d got %0d exp %0d", f, fe_seen, m_fe); end
      checks++; if (peak_idx !== IW'(m_idx)) begin errors++; $display("FAIL rnd_idx f%0d got %0d exp %0d", f, peak_idx, m_idx); end
      checks++; if (peak_amp !== AW'(m_amp)) begin errors++; $display("FAIL rnd_amp f%0d got %0d exp %0d", f, peak_amp, m_amp); end
      checks++; if (frame_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt f%0d got %0d exp %0d", f, frame_cnt, m_cnt); end
      checks++; if (busy !== m_in) begin errors++; $display("FAIL rnd_busy f%0d got %b exp %b", f, busy, m_in); end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_tie_mirror();
    test_short();
    test_restart();
    test_gappy_reset();
    test_dc();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
